window_3x3_gen: RTL
===================

Name: window_3x3_gen

Overview:
- Producer side of the 3x3 window interface consumed by the edge-preserving and Sobel filters.
- Accepts a raster-order grayscale pixel stream, one pixel per accepted cycle.
- Stores the two previous lines in line buffers.
- Emits a packed 3x3 neighbourhood (window_valid/window_flat) plus the centre coordinate for every fully interior pixel.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel.
- IMG_WIDTH, 640, pixels per line (must be >= 3).
- IMG_HEIGHT, 480, lines per frame (must be >= 3).
- COL_W, $clog2(IMG_WIDTH), column counter width (derived, localparam).
- ROW_W, $clog2(IMG_HEIGHT), row counter width (derived, localparam).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  marks the current cycle's pixel as (row 0, col 0); resets position counters.
- pixel_valid  in  1  pixel_in is valid this cycle; no backpressure, every valid pixel is accepted.
- pixel_in  in  PIXEL_WIDTH  incoming pixel.
- window_valid  out  1  window_flat and centre coordinates are valid this cycle.
- window_flat  out  PIXEL_WIDTH*9  packed window; slice k = [PIXEL_WIDTH*k +: PIXEL_WIDTH], with k = 3*r + c.
  - r=0 is the oldest line; c=0 is the oldest column.
  - k=4 is the centre; k=8 is the newest pixel.
- center_col  out  COL_W  column of the window centre.
- center_row  out  ROW_W  row of the window centre.
- frame_done  out  1  one-cycle pulse with the last window of a frame.
- frame_overrun  out  1  sticky; set when a pixel arrives after the frame has completed.

Behaviour:
- Reset (async, rst_n low):
  - window_valid, frame_done and frame_overrun go to 0.
  - window_flat, center_col and center_row go to 0.
  - Column and row counters go to 0; the shift-register window is cleared.
  - Line-buffer contents are not cleared. Stale data never reaches the output because rows 0–1 produce no windows.
- Position tracking:
  - col increments on each accepted pixel and wraps to 0 at IMG_WIDTH-1, at which point row increments.
  - After pixel (IMG_HEIGHT-1, IMG_WIDTH-1), the block enters state DONE.
- State machine:
  - IDLE: wait for pixel_valid && frame_start.
    - A pixel_valid without frame_start in IDLE is dropped and does not set overrun.
  - STREAM: accept pixels.
    - frame_start with pixel_valid in any state restarts the frame with this pixel at (0,0). Stage-2 output of any in-flight pixel still completes.
    - frame_start without pixel_valid is ignored.
  - DONE: pixel_valid without frame_start sets frame_overrun and the pixel is dropped. frame_start && pixel_valid restarts at (0,0).
  - frame_overrun is cleared only by reset.
- Pipeline, fixed latency of 2 cycles from the accepting pixel_valid edge to window_valid:
  - Stage 1: read both line buffers at address col; write pixel_in into line buffer 0 at col. Line buffer 0 shifts into line buffer 1 at the same address (read-before-write).
  - Stage 2: shift the three column taps {lb1_rd, lb0_rd, pixel} into the 3x3 register window.
  - Registered outputs are driven on the following edge.
- Emit condition: window_valid=1 iff the accepted pixel has row>=2 and col>=2.
  - Centre is (row-1, col-1).
  - Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
  - No border padding: columns 0–1 of each line only fill the taps.
- Window hold: window_flat holds its value when window_valid=0. Consumers must qualify on valid.
- Gaps: pixel_valid may be low for any number of cycles, including across line ends. Counters and taps hold. Output spacing mirrors input spacing.
- frame_done: asserted in the same cycle as window_valid for centre (IMG_HEIGHT-2, IMG_WIDTH-2).
- Widths: no arithmetic beyond the counters; the counters never exceed their max values.

Decomposition:
- Shared package (sobel_pkg):
  - PIXEL_WIDTH default.
  - Window slice index constants (WIN_P00..WIN_P22 = 0..8, WIN_CENTER = 4).
  - Image dimension defaults.
- One sub-module: line_ram.
  - Simple dual-port, IMG_WIDTH x PIXEL_WIDTH, synchronous read, write-first disabled (read returns old data).
  - Instantiated twice so it infers BSRAM on Tang Nano 4K.

Test Plan:
- Image size and stimulus: IMG_WIDTH=4, IMG_HEIGHT=4; stream pixel=(row<<4)|col with frame_start on the first pixel.
  - Required response: first window_valid 2 cycles after pixel (2,2), window_flat slices 0..8 = 00,01,02,10,11,12,20,21,22, centre (1,1).
  - Exactly 4 windows total. frame_done occurs with the centre (2,2) window, p22=0x33.
- Same 4x4 stream with random 0–3 idle cycles between pixels -> identical window contents and count; each window_valid occurs exactly 2 cycles after its triggering pixel.
- Overrun and restart, 4x4:
  - 17th pixel without frame_start -> frame_overrun=1 and no window.
  - Then frame_start+pixel -> new frame windows are correct; overrun stays 1.
- frame_start asserted at pixel (2,1) of a 4x4 frame -> that pixel becomes (0,0); no window is emitted until new row 2, col 2. Windows contain only new-frame values.
- Reset mid-frame: assert rst_n low for 1 cycle during row 3 -> all outputs are 0 immediately (async). Pixels without frame_start are dropped; the next full frame produces the correct 4 windows.
- Default 640x480 full frame with an incrementing pattern -> 638*478 windows. Spot-check the centre (1,1) and centre (478,638) windows against a reference model.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared definitions for the 3x3 window producer and the filters that consume its packed window.
package sobel_pkg;

  localparam int PIXEL_WIDTH_DEF = 8;
  localparam int IMG_WIDTH_DEF   = 640;
  localparam int IMG_HEIGHT_DEF  = 480;

  // Slice index k = 3*r + c; r=0 is the oldest line, c=0 the oldest column.
  localparam int WIN_P00    = 0;
  localparam int WIN_P01    = 1;
  localparam int WIN_P02    = 2;
  localparam int WIN_P10    = 3;
  localparam int WIN_P11    = 4;
  localparam int WIN_P12    = 5;
  localparam int WIN_P20    = 6;
  localparam int WIN_P21    = 7;
  localparam int WIN_P22    = 8;
  localparam int WIN_CENTER = WIN_P11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } win_state_t;

endpackage

// File: rtl/line_ram.sv
// One-line pixel store: simple dual-port, synchronous read returning pre-write data.
// Latency 1 cycle on read; no flow control, caller qualifies enables.
module line_ram
  import sobel_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH_DEF,
  parameter int WIDTH = PIXEL_WIDTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/window_3x3_gen.sv
// Raster pixel stream -> packed 3x3 neighbourhood for every interior pixel; 2-cycle latency.
// No backpressure: every valid pixel in a frame is accepted, output spacing follows input spacing.
module window_3x3_gen
  import sobel_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF,
  localparam int COL_W      = $clog2(IMG_WIDTH),
  localparam int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     pixel_valid,
  input  logic [PIXEL_WIDTH-1:0]   pixel_in,
  output logic                     window_valid,
  output logic [PIXEL_WIDTH*9-1:0] window_flat,
  output logic [COL_W-1:0]         center_col,
  output logic [ROW_W-1:0]         center_row,
  output logic                     frame_done,
  output logic                     frame_overrun
);

  localparam int PW = PIXEL_WIDTH;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  win_state_t       state_q, state_d;
  logic [COL_W-1:0] col_q, pos_col, s1_col;
  logic [ROW_W-1:0] row_q, pos_row, s1_row;
  logic             restart, accept, overrun_hit, line_end, frame_end;
  logic             s1_vld, s1_emit, s1_last;
  logic [PW-1:0]    s1_pix, lb0_rd, lb1_rd;
  logic [PW*9-1:0]  win_q, win_nxt;

  // A restarting pixel takes position (0,0) regardless of the counters.
  always_comb begin
    restart     = pixel_valid && frame_start;
    accept      = restart || (pixel_valid && state_q == ST_STREAM);
    overrun_hit = pixel_valid && !frame_start && state_q == ST_DONE;
    pos_col     = restart ? '0 : col_q;
    pos_row     = restart ? '0 : row_q;
    line_end    = pos_col == COL_LAST;
    frame_end   = line_end && pos_row == ROW_LAST;
    state_d     = state_q;
    if (accept) state_d = frame_end ? ST_DONE : ST_STREAM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q         <= '0;
      row_q         <= '0;
      frame_overrun <= 1'b0;
    end else begin
      if (accept) begin
        if (line_end) begin
          col_q <= '0;
          row_q <= frame_end ? '0 : pos_row + 1'b1;
        end else begin
          col_q <= pos_col + 1'b1;
          row_q <= pos_row;
        end
      end
      if (overrun_hit) frame_overrun <= 1'b1;
    end
  end

  // Stage 1: line buffers read at the pixel's column alongside this register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_emit <= 1'b0;
      s1_last <= 1'b0;
      s1_pix  <= '0;
      s1_col  <= '0;
      s1_row  <= '0;
    end else begin
      s1_vld  <= accept;
      s1_emit <= accept && pos_row >= ROW_W'(2) && pos_col >= COL_W'(2);
      s1_last <= accept && frame_end;
      if (accept) begin
        s1_pix <= pixel_in;
        s1_col <= pos_col;
        s1_row <= pos_row;
      end
    end
  end

  // lb1 takes lb0's pre-write word one cycle later at the same column.
  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PW)) u_lb0 (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (pos_col),
    .wr_data (pixel_in),
    .rd_en   (accept),
    .rd_addr (pos_col),
    .rd_data (lb0_rd)
  );

  line_ram #(.DEPTH(IMG_WIDTH), .WIDTH(PW)) u_lb1 (
    .clk     (clk),
    .wr_en   (s1_vld),
    .wr_addr (s1_col),
    .wr_data (lb0_rd),
    .rd_en   (accept),
    .rd_addr (pos_col),
    .rd_data (lb1_rd)
  );

  always_comb begin
    win_nxt = win_q;
    for (int r = 0; r < 3; r++) begin
      win_nxt[PW*(3*r)   +: PW] = win_q[PW*(3*r+1) +: PW];
      win_nxt[PW*(3*r+1) +: PW] = win_q[PW*(3*r+2) +: PW];
    end
    win_nxt[PW*WIN_P02 +: PW] = lb1_rd;
    win_nxt[PW*WIN_P12 +: PW] = lb0_rd;
    win_nxt[PW*WIN_P22 +: PW] = s1_pix;
  end

  // Stage 2: taps shift on every pixel, outputs load only on emitting ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      window_flat  <= '0;
      center_col   <= '0;
      center_row   <= '0;
    end else begin
      window_valid <= s1_emit;
      frame_done   <= s1_last;
      if (s1_vld) win_q <= win_nxt;
      if (s1_emit) begin
        window_flat <= win_nxt;
        center_col  <= s1_col - 1'b1;
        center_row  <= s1_row - 1'b1;
      end
    end
  end

endmodule
